clk_div_sched: RTL and testbench

Programmable clock-enable scheduler for the divider path. One free-running counter is shared among NCH consumer channels. Each channel gets a one-cycle enable strobe every 2^e cycles and a matching divided square wave. Software-side masters reconfigure channels through a valid/ready port, and the controller applies each change only at the counter wrap so that no output glitches or produces a runt period.

---
 rtl/clk_div_sched.sv | 135 +++++++++++++
 tb/tb_clk_div_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// Shared-counter clock-enable scheduler: per-channel 2^e strobes and divided clocks, reconfigured only at counter wrap.
// Optional out-of-range error pulse port enabled by defining CLK_DIV_SCHED_ERR_EN.
module clk_div_sched #(
  parameter int NCH   = 3,
  parameter int CNT_W = 8,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [3:0]       cfg_exp,
  input  logic             cfg_on,
  output logic             cfg_done,
`ifdef CLK_DIV_SCHED_ERR_EN
  output logic             cfg_err,
`endif
  output logic [NCH-1:0]   en_o,
  output logic [NCH-1:0]   ck_o,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [NCH-1:0]   r_on;
  logic [3:0]       r_exp [NCH];
  logic [NCH-1:0]   r_en;
  logic [NCH-1:0]   r_ck;
  logic             r_done;
  logic [CH_W-1:0]  r_sh_ch;
  logic [3:0]       r_sh_exp;
  logic             r_sh_on;

  logic             w_ch_ok;
  logic             w_accept;
  logic             w_apply;
  logic [3:0]       w_exp_clamped;
  logic [NCH-1:0]   w_eff_on;
  logic [3:0]       w_eff_exp [NCH];
  logic [NCH-1:0]   w_strobe;

  // Mask of the low e bits; e = CNT_W covers the whole counter.
  function automatic logic [CNT_W-1:0] low_mask(input logic [3:0] e);
    logic [CNT_W-1:0] m;
    for (int b = 0; b < CNT_W; b++) m[b] = (b < int'(e));
    return m;
  endfunction

  assign w_ch_ok       = (int'(cfg_ch) < NCH);
  assign w_accept      = (r_state == ST_IDLE) && cfg_valid && w_ch_ok;
  assign w_apply       = (r_state == ST_PEND) && (r_cnt == '1);
  assign w_exp_clamped = (cfg_exp > 4'(CNT_W)) ? 4'(CNT_W) : cfg_exp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (w_accept) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (w_apply) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The pending request already governs the apply edge itself.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_eff_on[i]  = r_on[i];
      w_eff_exp[i] = r_exp[i];
      if (w_apply && (int'(r_sh_ch) == i)) begin
        w_eff_on[i]  = r_sh_on;
        w_eff_exp[i] = r_sh_exp;
      end
      w_strobe[i] = w_eff_on[i] && ((r_cnt | ~low_mask(w_eff_exp[i])) == '1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sh_ch  <= cfg_ch;
      r_sh_exp <= w_exp_clamped;
      r_sh_on  <= cfg_on;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_on   <= '0;
      r_en   <= '0;
      r_ck   <= '0;
      r_done <= 1'b0;
      for (int i = 0; i < NCH; i++) r_exp[i] <= '0;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_done <= w_apply;
      for (int i = 0; i < NCH; i++) begin
        r_on[i]  <= w_eff_on[i];
        r_exp[i] <= w_eff_exp[i];
        r_en[i]  <= w_strobe[i];
        r_ck[i]  <= w_eff_on[i] ? (r_ck[i] ^ w_strobe[i]) : 1'b0;
      end
    end
  end

`ifdef CLK_DIV_SCHED_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= (r_state == ST_IDLE) && cfg_valid && !w_ch_ok;
  end

  assign cfg_err = r_err;
`endif

  assign cfg_done = r_done;
  assign en_o     = r_en;
  assign ck_o     = r_ck;
  assign cnt_o    = r_cnt;

endmodule

// File: tb/tb_clk_div_sched.sv
// Randomized and directed bench for clk_div_sched (NCH=3, CNT_W=4) against an arithmetic reference model.
module tb_clk_div_sched;
  localparam int NCH   = 3;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [3:0] cfg_exp;
  logic       cfg_on;
  wire        cfg_ready;
  wire        cfg_done;
  wire [2:0]  en_o;
  wire [2:0]  ck_o;
  wire [3:0]  cnt_o;
`ifdef CLK_DIV_SCHED_ERR_EN
  wire        cfg_err;
`endif

  int checks   = 0;
  int failures = 0;

  clk_div_sched #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_exp   (cfg_exp),
    .cfg_on    (cfg_on),
    .cfg_done  (cfg_done),
`ifdef CLK_DIV_SCHED_ERR_EN
    .cfg_err   (cfg_err),
`endif
    .en_o      (en_o),
    .ck_o      (ck_o),
    .cnt_o     (cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: channel config, pending request, expected outputs.
  int       m_cnt;
  bit [2:0] m_on;
  int       m_e [NCH];
  bit [2:0] m_en;
  bit [2:0] m_ck;
  bit       m_pend;
  int       m_pch;
  int       m_pe;
  bit       m_pon;
  bit       m_done;
  bit       m_err;

  logic [11:0] act_v;
  logic [11:0] exp_v;
  assign act_v = {en_o, ck_o, cnt_o, cfg_ready, cfg_done};
  assign exp_v = {m_en, m_ck, 4'(m_cnt), ~m_pend, m_done};

  task automatic model_step();
    bit idle, apply, strobe;
    if (!reset) begin
      m_cnt = 0; m_on = '0; m_en = '0; m_ck = '0;
      m_pend = 0; m_done = 0; m_err = 0;
      for (int i = 0; i < NCH; i++) m_e[i] = 0;
    end else begin
      idle   = !m_pend;
      apply  = m_pend && (m_cnt == 15);
      m_done = apply;
      m_err  = idle && cfg_valid && (int'(cfg_ch) >= NCH);
      if (apply) begin
        m_on[m_pch] = m_pon;
        m_e[m_pch]  = m_pe;
        m_pend      = 0;
      end
      if (idle && cfg_valid && (int'(cfg_ch) < NCH)) begin
        m_pend = 1;
        m_pch  = int'(cfg_ch);
        m_pe   = (cfg_exp > 4) ? 4 : int'(cfg_exp);
        m_pon  = cfg_on;
      end
      for (int i = 0; i < NCH; i++) begin
        strobe  = m_on[i] && (((m_cnt + 1) % (1 << m_e[i])) == 0);
        m_en[i] = strobe;
        m_ck[i] = m_on[i] ? (m_ck[i] ^ strobe) : 1'b0;
      end
      m_cnt = (m_cnt + 1) % 16;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic send(input int ch, input int ex, input bit on);
    int n;
    cfg_ch = 2'(ch); cfg_exp = 4'(ex); cfg_on = on; cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 40) begin tick(); n++; end
    if (n >= 40) begin
      failures++;
      $display("FAIL send_timeout ready=%b required=1", cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_exp = '0; cfg_on = 1'b0;
    repeat (3) tick();
    checks++;
    if (act_v !== 12'b000_000_0000_1_0) begin
      failures++;
      $display("FAIL reset_state act=%b required=%b", act_v, 12'b000_000_0000_1_0);
    end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cnt_o !== 4'(k)) begin
        failures++;
        $display("FAIL reset_count act=%0d required=%0d", cnt_o, k);
      end
      tick();
    end
  endtask

  task automatic test_enable();
    int dones = 0, hi_len = 0, n = 0;
    bit seen = 0;
    while (cnt_o !== 4'd3 && n < 20) begin tick(); n++; end
    cfg_ch = 2'd0; cfg_exp = 4'd2; cfg_on = 1'b1; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL enable_model act=%b required=%b", act_v, exp_v);
      end
      if (cfg_done) begin
        dones++;
        seen = 1;
        checks++;
        if (cnt_o !== 4'd0) begin
          failures++;
          $display("FAIL enable_apply_cnt act=%0d required=0", cnt_o);
        end
      end
      if (seen) begin
        checks++;
        if (en_o[0] !== (cnt_o[1:0] == 2'b00)) begin
          failures++;
          $display("FAIL enable_strobe cnt=%0d act=%b required=%b", cnt_o, en_o[0], cnt_o[1:0] == 2'b00);
        end
        if (ck_o[0]) hi_len++;
        else if (hi_len > 0) begin
          checks++;
          if (hi_len != 4) begin
            failures++;
            $display("FAIL enable_ck_half act=%0d required=4", hi_len);
          end
          hi_len = 0;
        end
      end
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL enable_done_count act=%0d required=1", dones);
    end
  endtask

  task automatic test_retime();
    int hi_len = 0;
    bit seen = 0;
    send(1, 0, 1);
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL retime_setup act=%b required=%b", act_v, exp_v);
      end
    end
    send(1, 3, 1);
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL retime_model act=%b required=%b", act_v, exp_v);
      end
      if (cfg_done) begin seen = 1; hi_len = 0; end
      checks++;
      if (!seen && en_o[1] !== 1'b1) begin
        failures++;
        $display("FAIL retime_before act=%b required=1", en_o[1]);
      end else if (seen && en_o[1] !== (cnt_o[2:0] == 3'd0)) begin
        failures++;
        $display("FAIL retime_after cnt=%0d act=%b required=%b", cnt_o, en_o[1], cnt_o[2:0] == 3'd0);
      end
      if (seen) begin
        if (ck_o[1]) hi_len++;
        else if (hi_len > 0) begin
          checks++;
          if (hi_len != 8) begin
            failures++;
            $display("FAIL retime_ck_half act=%0d required=8", hi_len);
          end
          hi_len = 0;
        end
      end
    end
  endtask

  task automatic test_disable();
    bit seen = 0;
    send(0, 0, 0);
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL disable_model act=%b required=%b", act_v, exp_v);
      end
      if (cfg_done) seen = 1;
      if (seen) begin
        checks++;
        if ({en_o[0], ck_o[0]} !== 2'b00 || en_o[1] !== (cnt_o[2:0] == 3'd0)) begin
          failures++;
          $display("FAIL disable_after en=%b ck=%b cnt=%0d required en0=0 ck0=0 en1=%b",
                   en_o, ck_o, cnt_o, cnt_o[2:0] == 3'd0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, dones = 0;
    cfg_ch = 2'd2; cfg_exp = 4'd1; cfg_on = 1'b1; cfg_valid = 1'b1;
    while (!cfg_ready && n < 40) begin tick(); n++; end
    tick();
    cfg_ch = 2'd0; cfg_exp = 4'd0; cfg_on = 1'b1;
    n = 0;
    while (!cfg_done && n < 40) begin
      tick(); n++;
      checks++;
      if (act_v !== exp_v || (!cfg_done && cfg_ready !== 1'b0)) begin
        failures++;
        $display("FAIL b2b_first act=%b required=%b", act_v, exp_v);
      end
    end
    checks++;
    if (cfg_done !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done_ready done=%b ready=%b required 1 1", cfg_done, cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept ready=%b required=0", cfg_ready);
    end
    for (int c = 0; c < 24; c++) begin
      tick();
      if (cfg_done) dones++;
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL b2b_second act=%b required=%b", act_v, exp_v);
      end
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL b2b_done_count act=%0d required=1", dones);
    end
  endtask

  task automatic test_error_reset();
    int n = 0;
    cfg_ch = 2'd3; cfg_exp = 4'd1; cfg_on = 1'b1; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (act_v !== exp_v || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL err_accept act=%b required=%b", act_v, exp_v);
    end
`ifdef CLK_DIV_SCHED_ERR_EN
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++;
      $display("FAIL err_pulse act=%b required=1", cfg_err);
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL err_single act=%b required=0", cfg_err);
    end
`endif
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL err_nochange act=%b required=%b", act_v, exp_v);
      end
    end
    while (cnt_o !== 4'd5 && n < 20) begin tick(); n++; end
    send(2, 2, 1);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (act_v !== exp_v || en_o !== 3'b000 || ck_o !== 3'b000 || cfg_done !== 1'b0) begin
        failures++;
        $display("FAIL reset_pend act=%b required=%b", act_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      cfg_valid = ($urandom % 3) == 0;
      cfg_ch    = 2'($urandom % 4);
      cfg_exp   = 4'($urandom % 16);
      cfg_on    = ($urandom % 4) != 0;
      tick();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL random_vec cycle=%0d act=%b required=%b", c, act_v, exp_v);
      end
`ifdef CLK_DIV_SCHED_ERR_EN
      checks++;
      if (cfg_err !== m_err) begin
        failures++;
        $display("FAIL random_err cycle=%0d act=%b required=%b", c, cfg_err, m_err);
      end
`endif
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_enable();
    test_retime();
    test_disable();
    test_back_to_back();
    test_error_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
